oitf_tracker: RTL and testbench

- Parametrised outstanding-instruction tracking FIFO for the MIPS core pipeline. One entry is allocated per long-latency instruction at dispatch and retired in order at write-back.
- Each entry records the destination GPR index plus HI/LO write flags.
- Dispatch compares its source, destination and HI/LO operands against all valid entries to detect RAW/WAW hazards and stall.
- Generalises the single-purpose LO tracker: configurable depth, GPR tracking, HI and LO tracking, occupancy flags, flush and correct pointer wrap.

---
 rtl/oitf_tracker_pkg.sv | 12 +
 rtl/oitf_entry.sv | 75 +++++++
 rtl/oitf_tracker.sv | 109 ++++++++++
 tb/tb_oitf_tracker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oitf_tracker_pkg.sv
// Shared sizing for the outstanding-instruction tracker: register-address width
// and the entry-pointer width derived from the configured depth.
package oitf_tracker_pkg;

  localparam int RegAddrBusWidth = 5;

  // Pointer width for a power-of-two depth; a depth of 2 still needs one bit.
  function automatic int ptr_w_f(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/oitf_entry.sv
// One tracker slot: valid bit plus {rdwen, rdidx, hi, lo} payload, with its own
// hazard compare bits against the dispatching instruction's operands.
module oitf_entry
  import oitf_tracker_pkg::*;
#(
  parameter int REG_AW = RegAddrBusWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic              rdwen_i,
  input  logic [REG_AW-1:0] rdidx_i,
  input  logic              hi_i,
  input  logic              lo_i,
  input  logic [REG_AW-1:0] rs1idx_i,
  input  logic [REG_AW-1:0] rs2idx_i,
  input  logic [REG_AW-1:0] rdidx_cmp_i,
  output logic              rs1_hit_o,
  output logic              rs2_hit_o,
  output logic              rd_hit_o,
  output logic              hi_hit_o,
  output logic              lo_hit_o
);

  logic              vld_q, vld_d;
  logic              rdwen_q, rdwen_d;
  logic [REG_AW-1:0] rdidx_q, rdidx_d;
  logic              hi_q, hi_d;
  logic              lo_q, lo_d;

  // Flush wins over everything; set and clear never target the same slot.
  always_comb begin
    vld_d   = vld_q;
    rdwen_d = rdwen_q;
    rdidx_d = rdidx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (set_i) begin
      vld_d   = 1'b1;
      rdwen_d = rdwen_i;
      rdidx_d = rdidx_i;
      hi_d    = hi_i;
      lo_d    = lo_i;
    end else if (clr_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      rdwen_q <= 1'b0;
      rdidx_q <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      rdwen_q <= rdwen_d;
      rdidx_q <= rdidx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign rs1_hit_o = vld_q & rdwen_q & (rdidx_q == rs1idx_i);
  assign rs2_hit_o = vld_q & rdwen_q & (rdidx_q == rs2idx_i);
  assign rd_hit_o  = vld_q & rdwen_q & (rdidx_q == rdidx_cmp_i);
  assign hi_hit_o  = vld_q & hi_q;
  assign lo_hit_o  = vld_q & lo_q;

endmodule

// File: rtl/oitf_tracker.sv
// In-order outstanding-instruction FIFO: allocate at dispatch, retire at
// write-back, and flag RAW/WAW hazards on GPR, HI and LO against live entries.
module oitf_tracker
  import oitf_tracker_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = ptr_w_f(DEPTH),
  parameter int REG_AW = RegAddrBusWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alc_vld,
  output logic              alc_rdy,
  input  logic              alc_rdwen,
  input  logic [REG_AW-1:0] alc_rdidx,
  input  logic              alc_hi,
  input  logic              alc_lo,
  output logic [PTR_W-1:0]  alc_ptr,
  input  logic              ret_vld,
  output logic [PTR_W-1:0]  ret_ptr,
  input  logic              flush,
  input  logic              rs1en,
  input  logic              rs2en,
  input  logic [REG_AW-1:0] rs1idx,
  input  logic [REG_AW-1:0] rs2idx,
  input  logic              rden,
  input  logic [REG_AW-1:0] rdidx,
  input  logic              rd_hi_en,
  input  logic              rd_lo_en,
  output logic              rs1_match,
  output logic              rs2_match,
  output logic              rd_match,
  output logic              hi_match,
  output logic              lo_match,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] alc_ptr_q, alc_ptr_d;
  logic [PTR_W:0] ret_ptr_q, ret_ptr_d;
  logic           alc_fire, ret_fire;

  assign empty = (alc_ptr_q == ret_ptr_q);
  assign full  = (alc_ptr_q[PTR_W-1:0] == ret_ptr_q[PTR_W-1:0]) &&
                 (alc_ptr_q[PTR_W] != ret_ptr_q[PTR_W]);
  assign count   = alc_ptr_q - ret_ptr_q;
  assign alc_rdy = ~full;
  assign alc_ptr = alc_ptr_q[PTR_W-1:0];
  assign ret_ptr = ret_ptr_q[PTR_W-1:0];

  assign alc_fire = alc_vld & ~full & ~flush;
  assign ret_fire = ret_vld & ~empty & ~flush;

  always_comb begin
    alc_ptr_d = alc_ptr_q;
    ret_ptr_d = ret_ptr_q;
    if (flush) begin
      alc_ptr_d = '0;
      ret_ptr_d = '0;
    end else begin
      if (alc_fire) alc_ptr_d = alc_ptr_q + 1'b1;
      if (ret_fire) ret_ptr_d = ret_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alc_ptr_q <= '0;
      ret_ptr_q <= '0;
    end else begin
      alc_ptr_q <= alc_ptr_d;
      ret_ptr_q <= ret_ptr_d;
    end
  end

  logic [DEPTH-1:0] rs1_hits, rs2_hits, rd_hits, hi_hits, lo_hits;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    oitf_entry #(.REG_AW(REG_AW)) u_entry (
      .clk         (clk),
      .rst         (rst),
      .set_i       (alc_fire && (alc_ptr_q[PTR_W-1:0] == PTR_W'(g))),
      .clr_i       (ret_fire && (ret_ptr_q[PTR_W-1:0] == PTR_W'(g))),
      .flush_i     (flush),
      .rdwen_i     (alc_rdwen),
      .rdidx_i     (alc_rdidx),
      .hi_i        (alc_hi),
      .lo_i        (alc_lo),
      .rs1idx_i    (rs1idx),
      .rs2idx_i    (rs2idx),
      .rdidx_cmp_i (rdidx),
      .rs1_hit_o   (rs1_hits[g]),
      .rs2_hit_o   (rs2_hits[g]),
      .rd_hit_o    (rd_hits[g]),
      .hi_hit_o    (hi_hits[g]),
      .lo_hit_o    (lo_hits[g])
    );
  end

  // $zero is never a real producer, so index 0 is excluded from GPR hazards.
  assign rs1_match = rs1en & (|rs1idx) & (|rs1_hits);
  assign rs2_match = rs2en & (|rs2idx) & (|rs2_hits);
  assign rd_match  = rden  & (|rdidx)  & (|rd_hits);
  assign hi_match  = rd_hi_en & (|hi_hits);
  assign lo_match  = rd_lo_en & (|lo_hits);

endmodule

// File: tb/tb_oitf_tracker.sv
// Bench for oitf_tracker: directed scenarios plus random traffic, checked each
// cycle against a queue-based reference of the in-flight instructions.
module tb_oitf_tracker;

  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int REG_AW = 5;
  localparam int VW     = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              alc_vld, alc_rdy, alc_rdwen, alc_hi, alc_lo;
  logic [REG_AW-1:0] alc_rdidx;
  logic [PTR_W-1:0]  alc_ptr, ret_ptr;
  logic              ret_vld, flush;
  logic              rs1en, rs2en, rden, rd_hi_en, rd_lo_en;
  logic [REG_AW-1:0] rs1idx, rs2idx, rdidx;
  logic              rs1_match, rs2_match, rd_match, hi_match, lo_match;
  logic              empty, full;
  logic [PTR_W:0]    count;

  oitf_tracker #(.DEPTH(DEPTH), .PTR_W(PTR_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .alc_vld(alc_vld), .alc_rdy(alc_rdy), .alc_rdwen(alc_rdwen),
    .alc_rdidx(alc_rdidx), .alc_hi(alc_hi), .alc_lo(alc_lo),
    .alc_ptr(alc_ptr), .ret_vld(ret_vld), .ret_ptr(ret_ptr), .flush(flush),
    .rs1en(rs1en), .rs2en(rs2en), .rs1idx(rs1idx), .rs2idx(rs2idx),
    .rden(rden), .rdidx(rdidx), .rd_hi_en(rd_hi_en), .rd_lo_en(rd_lo_en),
    .rs1_match(rs1_match), .rs2_match(rs2_match), .rd_match(rd_match),
    .hi_match(hi_match), .lo_match(lo_match),
    .empty(empty), .full(full), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: in-flight instructions, oldest first
  typedef struct {
    logic              rdwen;
    logic [REG_AW-1:0] rdidx;
    logic              hi;
    logic              lo;
  } ent_t;

  ent_t model_q[$];
  int   alc_cnt;
  int   ret_cnt;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] exp_q[$];
  string         name_q[$];
  logic [VW-1:0] dut_vec;

  assign dut_vec = {empty, full, count, alc_rdy, alc_ptr, ret_ptr,
                    rs1_match, rs2_match, rd_match, hi_match, lo_match};

  function automatic logic [VW-1:0] expect_vec();
    int  n;
    logic m1, m2, md, mh, ml;
    n  = model_q.size();
    m1 = 0; m2 = 0; md = 0; mh = 0; ml = 0;
    foreach (model_q[i]) begin
      if (model_q[i].rdwen && model_q[i].rdidx == rs1idx) m1 = 1;
      if (model_q[i].rdwen && model_q[i].rdidx == rs2idx) m2 = 1;
      if (model_q[i].rdwen && model_q[i].rdidx == rdidx)  md = 1;
      if (model_q[i].hi) mh = 1;
      if (model_q[i].lo) ml = 1;
    end
    m1 = m1 && rs1en && (rs1idx != 0);
    m2 = m2 && rs2en && (rs2idx != 0);
    md = md && rden && (rdidx != 0);
    mh = mh && rd_hi_en;
    ml = ml && rd_lo_en;
    return {(n == 0), (n == DEPTH), 3'(n), (n != DEPTH),
            2'(alc_cnt % DEPTH), 2'(ret_cnt % DEPTH), m1, m2, md, mh, ml};
  endfunction

  task automatic model_reset();
    model_q.delete();
    alc_cnt = 0;
    ret_cnt = 0;
  endtask

  // Apply one clock edge to the model using the inputs held during the cycle.
  task automatic model_edge();
    bit do_ret, do_alc;
    ent_t e;
    if (flush) begin
      model_reset();
    end else begin
      do_ret = ret_vld && (model_q.size() > 0);
      do_alc = alc_vld && (model_q.size() < DEPTH);
      if (do_ret) begin
        void'(model_q.pop_front());
        ret_cnt = (ret_cnt + 1) % (2 * DEPTH);
      end
      if (do_alc) begin
        e.rdwen = alc_rdwen; e.rdidx = alc_rdidx; e.hi = alc_hi; e.lo = alc_lo;
        model_q.push_back(e);
        alc_cnt = (alc_cnt + 1) % (2 * DEPTH);
      end
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    alc_vld = 0; alc_rdwen = 0; alc_rdidx = '0; alc_hi = 0; alc_lo = 0;
    ret_vld = 0; flush = 0;
    rs1en = 0; rs2en = 0; rs1idx = '0; rs2idx = '0;
    rden = 0; rdidx = '0; rd_hi_en = 0; rd_lo_en = 0;
  endtask

  task automatic cycle(input string nm);
    exp_q.push_back(expect_vec());
    name_q.push_back(nm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_alloc(input logic we, input int idx, input logic h, input logic l,
                          input logic rv, input string nm);
    alc_vld = 1; alc_rdwen = we; alc_rdidx = REG_AW'(idx); alc_hi = h; alc_lo = l;
    ret_vld = rv;
    cycle(nm);
    alc_vld = 0; ret_vld = 0;
  endtask

  // scoreboard monitor: compare away from the active edge
  always @(negedge clk) begin
    logic [VW-1:0] exp_v;
    string         nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      total++;
      if (dut_vec !== exp_v) begin
        bad++;
        $display("FAIL %s: got {emp,full,cnt,rdy,aptr,rptr,m1,m2,md,mh,ml}=%b want %b",
                 nm, dut_vec, exp_v);
      end
      if (empty && full) begin
        bad++;
        $display("FAIL %s_flags: empty and full both set", nm);
      end
    end
  end

  initial begin
    logic [VW-1:0] exp_v;
    rst = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state with a probe on r5
    rs1en = 1; rs1idx = 5;
    cycle("reset_idle");

    // single entry: RAW hit, still visible in the retire cycle
    do_alloc(1, 5, 0, 0, 0, "alloc_r5");
    rs1en = 1; rs1idx = 5; rs2en = 1; rs2idx = 6;
    cycle("match_r5");
    ret_vld = 1;
    cycle("retire_cycle_match");
    ret_vld = 0;
    cycle("after_retire");

    // fill, blocked 5th alloc, alloc+retire while full, then at count 3
    for (int i = 0; i < DEPTH; i++) do_alloc(1, i + 1, 0, 0, 0, "fill");
    rden = 1; rdidx = 3;
    cycle("full_state");
    do_alloc(1, 9, 0, 0, 0, "alloc_when_full");
    do_alloc(1, 10, 0, 0, 1, "full_alc_ret");
    do_alloc(1, 11, 0, 0, 1, "cnt3_alc_ret");
    cycle("cnt3_after");

    // drain, then run pairs to push pointers through the wrap
    ret_vld = 1;
    repeat (4) cycle("drain");
    ret_vld = 0;
    do_alloc(1, 7, 0, 0, 0, "wrap_seed");
    for (int i = 0; i < 10; i++) do_alloc(1, 7, 0, 0, 1, "wrap_pair");
    for (int i = 0; i < 6; i++) begin
      do_alloc(0, 0, 0, 0, 0, "wrap_alc");
      ret_vld = 1; cycle("wrap_ret"); ret_vld = 0;
    end
    ret_vld = 1; cycle("wrap_drain"); ret_vld = 0;

    // HI/LO tracking and $zero exclusion
    idle_inputs();
    do_alloc(0, 0, 0, 1, 0, "alloc_lo");
    rd_lo_en = 1; rd_hi_en = 1;
    cycle("lo_hit_hi_miss");
    do_alloc(1, 0, 0, 0, 0, "alloc_r0");
    rs1en = 1; rs1idx = 0; rden = 1; rdidx = 0;
    cycle("r0_no_match");

    // flush beats a concurrent allocate
    idle_inputs();
    do_alloc(1, 4, 1, 0, 0, "pre_flush_a");
    do_alloc(1, 5, 0, 1, 0, "pre_flush_b");
    alc_vld = 1; alc_rdwen = 1; alc_rdidx = 6; flush = 1;
    cycle("flush_with_alloc");
    idle_inputs();
    rs1en = 1; rs1idx = 4; rs2en = 1; rs2idx = 5; rden = 1; rdidx = 6;
    rd_hi_en = 1; rd_lo_en = 1;
    cycle("after_flush");

    // random traffic on a narrow register range to provoke hits
    for (int i = 0; i < 400; i++) begin
      alc_vld   = ($urandom_range(0, 99) < 55);
      alc_rdwen = $urandom_range(0, 1);
      alc_rdidx = REG_AW'($urandom_range(0, 7));
      alc_hi    = ($urandom_range(0, 3) == 0);
      alc_lo    = ($urandom_range(0, 3) == 0);
      ret_vld   = ($urandom_range(0, 99) < 45);
      flush     = ($urandom_range(0, 49) == 0);
      rs1en     = $urandom_range(0, 1);
      rs2en     = $urandom_range(0, 1);
      rden      = $urandom_range(0, 1);
      rs1idx    = REG_AW'($urandom_range(0, 7));
      rs2idx    = REG_AW'($urandom_range(0, 7));
      rdidx     = REG_AW'($urandom_range(0, 7));
      rd_hi_en  = $urandom_range(0, 1);
      rd_lo_en  = $urandom_range(0, 1);
      cycle("random");
    end

    // asynchronous reset in the middle of an allocate cycle
    idle_inputs();
    do_alloc(1, 3, 1, 1, 0, "pre_rst");
    alc_vld = 1; alc_rdwen = 1; alc_rdidx = 3; alc_hi = 1;
    rs1en = 1; rs1idx = 3; rd_hi_en = 1;
    #2 rst = 1;
    #1;
    model_reset();
    exp_v = expect_vec();
    total++;
    if (dut_vec !== exp_v) begin
      bad++;
      $display("FAIL async_rst: got %b want %b", dut_vec, exp_v);
    end
    @(posedge clk);
    #1 rst = 0;
    idle_inputs();
    rs1en = 1; rs1idx = 3; rd_hi_en = 1;
    cycle("post_rst");
    cycle("post_rst_idle");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
